pc_fetch_unit: RTL and testbench

//  Fetch stage directly upstream of the program ROM (12-bit address, 8-bit word).

---
 rtl/fetch_pkg.sv | 18 +
 rtl/program_counter.sv | 41 ++++
 rtl/pc_fetch_unit.sv | 95 +++++++++
 tb/tb_pc_fetch_unit.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared constants and state encoding for the program fetch stage.
package fetch_pkg;

  localparam int ADDR_W = 12;   // PC / ROM address width
  localparam int DATA_W = 8;    // ROM word width
  localparam int OPC_W  = 4;    // instr field width (oprnd takes the rest)

  // Program counter value after reset
  localparam logic [ADDR_W-1:0] PC_RST = '0;

  // Fetch FSM encoding; valid is asserted only in VALID
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    VALID = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/program_counter.sv
// Program counter with increment, synchronous load and a one-cycle wrap pulse.
module program_counter
  import fetch_pkg::*;
#(
  parameter int ADDR_W = fetch_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              inc,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_addr,
  output logic [ADDR_W-1:0] pc,
  output logic              wrap
);

  logic [ADDR_W-1:0] r_pc;
  logic              r_wrap;
  logic              w_at_max;

  assign w_at_max = &r_pc;

  // Load beats increment; wrap pulses only when an increment rolls all-ones to zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc   <= ADDR_W'(PC_RST);
      r_wrap <= 1'b0;
    end else if (load) begin
      r_pc   <= load_addr;
      r_wrap <= 1'b0;
    end else if (inc) begin
      r_pc   <= r_pc + 1'b1;
      r_wrap <= w_at_max;
    end else begin
      r_wrap <= 1'b0;
    end
  end

  assign pc   = r_pc;
  assign wrap = r_wrap;

endmodule

// File: rtl/pc_fetch_unit.sv
// Fetch stage: drives the ROM address from the PC, captures the returned word
// and offers it to the decoder through a valid/ready handshake.
module pc_fetch_unit
  import fetch_pkg::*;
#(
  parameter int ADDR_W = fetch_pkg::ADDR_W,
  parameter int DATA_W = fetch_pkg::DATA_W,
  parameter int OPC_W  = fetch_pkg::OPC_W
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enable,
  input  logic                    load,
  input  logic [ADDR_W-1:0]       load_addr,
  output logic [ADDR_W-1:0]       rom_addr,
  input  logic [DATA_W-1:0]       rom_data,
  output logic [OPC_W-1:0]        instr,
  output logic [DATA_W-OPC_W-1:0] oprnd,
  output logic                    valid,
  input  logic                    ready,
  output logic                    pc_wrap
);

  localparam int OPR_W = DATA_W - OPC_W;

  fetch_state_e      r_state;
  fetch_state_e      w_state_next;
  logic              w_capture;
  logic [OPC_W-1:0]  r_instr;
  logic [OPR_W-1:0]  r_oprnd;
  logic [ADDR_W-1:0] w_pc;

  program_counter #(
    .ADDR_W (ADDR_W)
  ) u_pc (
    .clk       (clk),
    .rst_n     (rst_n),
    .inc       (w_capture),
    .load      (load),
    .load_addr (load_addr),
    .pc        (w_pc),
    .wrap      (pc_wrap)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next state and capture strobe; a load overrides everything and drops any held word
  always_comb begin
    w_state_next = r_state;
    w_capture    = 1'b0;
    if (load) begin
      w_state_next = enable ? FETCH : IDLE;
    end else begin
      case (r_state)
        IDLE: begin
          if (enable) w_state_next = FETCH;
        end
        FETCH: begin
          if (enable) begin
            w_capture    = 1'b1;
            w_state_next = VALID;
          end
        end
        VALID: begin
          if (ready) w_state_next = enable ? FETCH : IDLE;
        end
        default: w_state_next = IDLE;
      endcase
    end
  end

  // Fetch register: rom_data is sampled only on the FETCH->VALID edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_instr <= '0;
      r_oprnd <= '0;
    end else if (w_capture) begin
      r_instr <= rom_data[DATA_W-1:OPR_W];
      r_oprnd <= rom_data[OPR_W-1:0];
    end
  end

  assign rom_addr = w_pc;
  assign instr    = r_instr;
  assign oprnd    = r_oprnd;
  assign valid    = (r_state == VALID);

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit with a combinational ROM model.
module tb_pc_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic        load;
  logic [11:0] load_addr;
  logic [11:0] rom_addr;
  logic [7:0]  rom_data;
  logic [3:0]  instr;
  logic [3:0]  oprnd;
  logic        valid;
  logic        ready;
  logic        pc_wrap;

  logic [7:0]  rom [4096];
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  assign rom_data = rom[rom_addr];

  pc_fetch_unit dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .enable    (enable),
    .load      (load),
    .load_addr (load_addr),
    .rom_addr  (rom_addr),
    .rom_data  (rom_data),
    .instr     (instr),
    .oprnd     (oprnd),
    .valid     (valid),
    .ready     (ready),
    .pc_wrap   (pc_wrap)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] exp_word [4];
    for (int i = 0; i < 4096; i++) rom[i] = i[7:0];
    rom[3] = 8'hA5;
    exp_word[0] = 8'h00;
    exp_word[1] = 8'h01;
    exp_word[2] = 8'h02;
    exp_word[3] = 8'hA5;

    rst_n = 1'b0; enable = 1'b0; load = 1'b0; load_addr = '0; ready = 1'b0;
    #12;
    chk("reset_pc", 32'(rom_addr), 32'h0);
    chk("reset_valid", 32'(valid), 32'h0);
    chk("reset_instr", 32'(instr), 32'h0);
    chk("reset_oprnd", 32'(oprnd), 32'h0);
    chk("reset_wrap", 32'(pc_wrap), 32'h0);
    rst_n = 1'b1; enable = 1'b1; ready = 1'b1;
    $display("reset released, sequential fetch begins");

    // Sequential fetch: FETCH and VALID alternate
    for (int w = 0; w < 4; w++) begin
      step();
      chk("seq_fetch_valid", 32'(valid), 32'h0);
      step();
      chk("seq_valid", 32'(valid), 32'h1);
      chk("seq_word", 32'({instr, oprnd}), 32'(exp_word[w]));
      chk("seq_pc", 32'(rom_addr), 32'(w + 1));
      $display("fetched word %0d: instr=%0h oprnd=%0h pc=%0h", w, instr, oprnd, rom_addr);
    end
    chk("a5_instr", 32'(instr), 32'hA);
    chk("a5_oprnd", 32'(oprnd), 32'h5);

    // Backpressure: hold for 5 cycles
    ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      step();
      chk("bp_valid", 32'(valid), 32'h1);
      chk("bp_word", 32'({instr, oprnd}), 32'hA5);
      chk("bp_pc", 32'(rom_addr), 32'h4);
    end
    ready = 1'b1;
    step();
    chk("bp_accept_valid", 32'(valid), 32'h0);
    chk("bp_accept_pc", 32'(rom_addr), 32'h4);
    step();
    chk("bp_next_word", 32'({instr, oprnd}), 32'h04);
    chk("bp_next_pc", 32'(rom_addr), 32'h5);
    $display("backpressure released, next word=%0h", {instr, oprnd});

    // Jump while valid && ready: word dropped
    load = 1'b1; load_addr = 12'h7F0;
    step();
    load = 1'b0;
    chk("jump_valid_dropped", 32'(valid), 32'h0);
    chk("jump_pc", 32'(rom_addr), 32'h7F0);
    chk("jump_word_kept", 32'({instr, oprnd}), 32'h04);
    step();
    chk("jump_word", 32'({instr, oprnd}), 32'hF0);
    chk("jump_pc_after", 32'(rom_addr), 32'h7F1);
    chk("jump_valid", 32'(valid), 32'h1);
    $display("jump to 7F0, word=%0h", {instr, oprnd});

    // Wrap from FFF
    load = 1'b1; load_addr = 12'hFFF;
    step();
    load = 1'b0;
    chk("wrap_load_pc", 32'(rom_addr), 32'hFFF);
    chk("wrap_pre_pulse", 32'(pc_wrap), 32'h0);
    step();
    chk("wrap_word", 32'({instr, oprnd}), 32'hFF);
    chk("wrap_pc", 32'(rom_addr), 32'h0);
    chk("wrap_pulse", 32'(pc_wrap), 32'h1);
    step();
    chk("wrap_pulse_end", 32'(pc_wrap), 32'h0);
    step();
    chk("wrap_next_word", 32'({instr, oprnd}), 32'h00);
    chk("wrap_next_pc", 32'(rom_addr), 32'h1);
    chk("wrap_next_valid", 32'(valid), 32'h1);
    $display("wrap done, pc=%0h", rom_addr);

    // Load collides with a wrapping increment: load wins
    load = 1'b1; load_addr = 12'hFFF;
    step();
    load_addr = 12'h123;
    step();
    load = 1'b0;
    chk("collide_pc", 32'(rom_addr), 32'h123);
    chk("collide_wrap", 32'(pc_wrap), 32'h0);
    chk("collide_valid", 32'(valid), 32'h0);
    $display("load/wrap collision, pc=%0h", rom_addr);

    // Enable gating in FETCH
    enable = 1'b0;
    for (int c = 0; c < 3; c++) begin
      step();
      chk("gate_valid", 32'(valid), 32'h0);
      chk("gate_pc", 32'(rom_addr), 32'h123);
      chk("gate_word", 32'({instr, oprnd}), 32'h00);
    end
    enable = 1'b1;
    step();
    chk("gate_capture_word", 32'({instr, oprnd}), 32'h23);
    chk("gate_capture_valid", 32'(valid), 32'h1);
    chk("gate_capture_pc", 32'(rom_addr), 32'h124);
    $display("enable gating done, word=%0h", {instr, oprnd});

    // Asynchronous reset mid-VALID
    ready = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_pc", 32'(rom_addr), 32'h0);
    chk("async_valid", 32'(valid), 32'h0);
    chk("async_instr", 32'(instr), 32'h0);
    chk("async_oprnd", 32'(oprnd), 32'h0);
    step();
    chk("async_hold_pc", 32'(rom_addr), 32'h0);
    ready = 1'b1;
    rst_n = 1'b1;
    step();
    chk("post_rst_fetch_valid", 32'(valid), 32'h0);
    chk("post_rst_addr", 32'(rom_addr), 32'h0);
    step();
    chk("post_rst_word", 32'({instr, oprnd}), 32'h00);
    chk("post_rst_pc", 32'(rom_addr), 32'h1);
    chk("post_rst_valid", 32'(valid), 32'h1);
    $display("reset recovery, first word=%0h", {instr, oprnd});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
